// File: rtl/dff_bank_arbiter.sv
// Write arbiter and sequencer for a DEPTH x WIDTH flop bank, with a registered read port.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default is round-robin.
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                      state, state_nxt;
    logic [PW-1:0]               ptr, ptr_nxt, base, win;
    logic                        found;
    logic [NREQ-1:0]             gnt_nxt;
    logic                        busy_nxt;
    logic [AW-1:0]               addr_lat;
    logic [WIDTH-1:0]            data_lat;
    logic [DEPTH-1:0][WIDTH-1:0] bank;

`ifdef ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    assign base = ptr;
`endif

    // Scan upward from base, wrapping; the first set request wins.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(base) + off) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = WRITE;
                    gnt_nxt[win] = 1'b1;
                    busy_nxt     = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
                    ptr_nxt      = '0;
`else
                    ptr_nxt      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
`endif
                end
            end
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            addr_lat <= '0;
            data_lat <= '0;
            rd_data  <= '0;
            bank     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            busy    <= busy_nxt;
            ptr     <= ptr_nxt;
            // Read samples the pre-write contents, so a same-edge write returns old data.
            rd_data <= bank[rd_addr];
            if (state == IDLE && found) begin
                addr_lat <= wr_addr[int'(win)*AW +: AW];
                data_lat <= wr_data[int'(win)*WIDTH +: WIDTH];
            end
            if (state == WRITE)
                bank[addr_lat] <= data_lat;
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed and randomized bench for dff_bank_arbiter against a transaction-level bank model.
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*AW-1:0]    wr_addr = '0;
    logic [NREQ*WIDTH-1:0] wr_data = '0;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [AW-1:0]         rd_addr = '0;
    logic [WIDTH-1:0]      rd_data;

    int compared = 0;
    int mismatched = 0;

    // Reference model: bank contents, rotation pointer, one pending write.
    int m_bank[DEPTH];
    int m_ptr;
    bit m_pend;
    int m_pa, m_pd;
    logic [NREQ-1:0]  exp_gnt;
    logic             exp_busy;
    logic [WIDTH-1:0] exp_rd;

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .gnt(gnt), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) m_bank[a] = 0;
        m_ptr = 0; m_pend = 0; m_pa = 0; m_pd = 0;
        exp_gnt = '0; exp_busy = 1'b0; exp_rd = '0;
    endtask

    task automatic model_edge();
        int k;
        bit hit;
        exp_rd = WIDTH'(m_bank[rd_addr]);
        exp_gnt = '0;
        if (m_pend) begin
            m_bank[m_pa] = m_pd;
            m_pend = 0;
        end else if (req != '0) begin
            hit = 0; k = 0;
            for (int o = 0; o < NREQ; o++) begin
                if (!hit && req[(m_ptr + o) % NREQ]) begin
                    hit = 1; k = (m_ptr + o) % NREQ;
                end
            end
            m_pa = int'(wr_addr[k*AW +: AW]);
            m_pd = int'(wr_data[k*WIDTH +: WIDTH]);
            m_pend = 1;
            exp_gnt[k] = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            m_ptr = (k + 1) % NREQ;
`endif
        end
        exp_busy = (exp_gnt != '0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_gnt", 32'(gnt), 32'(exp_gnt));
        chk("rst_busy", 32'(busy), 32'(exp_busy));
        chk("rst_rd_data", 32'(rd_data), 32'(exp_rd));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input int d);
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*WIDTH +: WIDTH] = WIDTH'(d);
    endtask

    logic [NREQ-1:0] rr_tab[9];

    initial begin
        model_clear();
        do_reset();

        // single write, read back two edges after grant
        set_req(0, 3, 8'hA5); rd_addr = 3'd3; req = 4'b0001;
        step(); chk("single_gnt", 32'(gnt), 32'h1);
        req = '0;
        step(); chk("single_gnt_drop", 32'(gnt), 32'h0);
        step(); chk("single_rd", 32'(rd_data), 32'hA5);

        // all requests held continuously
        do_reset();
`ifdef ARB_FIXED_PRIO_EN
        rr_tab = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
`else
        rr_tab = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
`endif
        for (int i = 0; i < NREQ; i++) set_req(i, i, 16 * i + 1);
        req = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            step(); chk($sformatf("rr_seq%0d", c), 32'(gnt), 32'(rr_tab[c]));
        end
        req = '0;

        // pointer wrap: grant req2, then req3 ahead of req1
        do_reset();
        req = 4'b0100; step(); req = '0; step();
        req = 4'b1010;
        step();
`ifndef ARB_FIXED_PRIO_EN
        chk("wrap_first", 32'(gnt), 32'h8);
`endif
        step(); step();
`ifndef ARB_FIXED_PRIO_EN
        chk("wrap_second", 32'(gnt), 32'h2);
`endif
        req = '0; step();

        // read during write to the same address
        do_reset();
        rd_addr = 3'd5; set_req(0, 5, 8'h11); req = 4'b0001;
        step(); req = '0; step(); step();
        set_req(0, 5, 8'h22); req = 4'b0001;
        step(); req = '0;
        chk("rdw_before", 32'(rd_data), 32'h11);
        step(); chk("rdw_edge", 32'(rd_data), 32'h11);
        step(); chk("rdw_after", 32'(rd_data), 32'h22);

        // async reset while a write is pending
        set_req(0, 2, 8'hFF); rd_addr = 3'd2; req = 4'b0001;
        step(); req = '0;
        chk("async_busy_pre", 32'(busy), 32'h1);
        @(negedge clk);
        do_reset();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            step();
            chk($sformatf("post_rst_rd%0d", a), 32'(rd_data), 32'h0);
        end

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            req = NREQ'($urandom);
            wr_addr = (NREQ*AW)'($urandom);
            wr_data = $urandom;
            rd_addr = AW'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                do_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Shared register-bank controller: arbitrates write access from NREQ requesters to a DEPTH x WIDTH bank of D flip-flops, sequences each write through a two-state FSM, and provides a registered read port. It sits between the bank's storage flops and the blocks that update them, so that exactly one requester drives the bank's write path in any cycle.

## Interface
- NREQ, 4, number of write requesters
- WIDTH, 8, data bits per bank entry
- DEPTH, 8, bank entries (power of two)
- AW, 3, address width, log2(DEPTH)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester write request, level
- wr_addr  in  NREQ*AW  requester i address at bits [i*AW +: AW]
- wr_data  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, registered
- busy  out  1  high while FSM in WRITE
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  registered read data

## Operation
- FSM states: IDLE, WRITE.
- IDLE, no req bit set: stay IDLE; gnt=0, busy=0.
- IDLE, any req bit set: select winner k, latch wr_addr/wr_data slice k, gnt <= one-hot k, busy <= 1, go WRITE.
- WRITE: bank[addr_lat] <= data_lat at the edge ending the cycle; gnt <= 0, busy <= 0, go IDLE unconditionally. req is ignored in WRITE.
- Round-robin selection: search from ptr upward modulo NREQ; first set req wins. After granting k, ptr <= (k+1) mod NREQ, updated on the IDLE->WRITE edge.
- Handshake: requester holds req, data and address stable until it sees gnt. It drops req during the gnt cycle. If req is still high when the FSM returns to IDLE, this is a new request and is arbitrated normally.
- Requester i's data is captured on the IDLE->WRITE edge. Later changes to its inputs have no effect on that write.
- Read: rd_data <= bank[rd_addr] on every edge, regardless of FSM state.
- Read and write to the same address on the same edge: rd_data returns the old value.
- Reset values: state IDLE, gnt 0, busy 0, ptr 0, rd_data 0, every bank entry 0.

## Timing
- Request to grant: req sampled high at edge E0, gnt/busy high after E0, for exactly one cycle.
- Grant to write: bank updated at E1, the edge after E0. A read with rd_addr = written address sampled at E2 returns new data.
- Peak throughput: one write per 2 cycles. Minimum gap between grants to any requesters is 2 cycles.
- Reset mid-WRITE: rst high clears state immediately, without waiting for clk. gnt/busy drop at once, the pending write is discarded, and the bank clears to 0.
- rst deassertion: first arbitration at the first rising edge with rst low.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, lowest set req index wins. ptr is not implemented or held at 0. Starvation of high indices is permitted.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Reset: assert rst mid-sim -> gnt=0, busy=0, rd_data=0 for all 8 addresses after reset.
- Single write: req[0]=1, wr_addr0=3, wr_data0=0xA5 -> gnt=4'b0001 for one cycle; rd_addr=3 reads 0xA5 two edges after grant.
- All four req held continuously, round-robin -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001. With ARB_FIXED_PRIO_EN -> 0001,0000 repeating.
- Pointer wrap: after a grant to req2 (ptr=3), with req[1] and req[3] set -> grant req3, then req1.
- Read-during-write: addr 5 holds 0x11, write 0x22 to addr 5 with rd_addr=5 -> rd_data 0x11 at write edge, 0x22 at following edge.
- Async reset during WRITE (data 0xFF to addr 2) -> gnt/busy fall before next clk edge; addr 2 reads 0x00 afterwards.
